// File: rtl/accel_run_ctrl_pkg.sv
// Shared types and default sizing for the accelerator run controller.
package accel_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IDLE,
        ST_START,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    localparam int RUN_CNT_W_DEF      = 16;
    localparam int BEAT_CNT_W_DEF     = 32;
    localparam int TIMEOUT_CYCLES_DEF = 1048576;

endpackage

// File: rtl/accel_run_ctrl_wdog.sv
// Inactivity watchdog: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed.
module accel_run_ctrl_wdog
    import accel_run_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign expired = en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt_q <= '0;
        end else if (!expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/accel_run_ctrl.sv
// ap_ctrl_hs initiator with idle-guarded select, run/beat counters.
// Optional watchdog: define ACCEL_RUN_CTRL_WATCHDOG_EN.
module accel_run_ctrl
    import accel_run_ctrl_pkg::*;
#(
    parameter int RUN_CNT_W      = RUN_CNT_W_DEF,
    parameter int BEAT_CNT_W     = BEAT_CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  cmd_start,
    input  logic                  cmd_use_enc,
    input  logic [RUN_CNT_W-1:0]  cmd_runs,
    input  logic                  cmd_abort,
    output logic                  USE_ENC,
    output logic                  ap_start,
    input  logic                  ap_ready,
    input  logic                  ap_done,
    input  logic                  ap_idle,
    input  logic                  mon_tvalid,
    input  logic                  mon_tready,
    output logic                  sts_busy,
    output logic                  sts_done,
    output logic                  sts_aborted,
    output logic                  sts_timeout,
    output logic [RUN_CNT_W-1:0]  sts_runs_done,
    output logic [BEAT_CNT_W-1:0] sts_beats
);

    state_e                  state_q, state_d;
    logic                    use_enc_q;
    logic                    ap_start_q;
    logic [RUN_CNT_W-1:0]    runs_q;
    logic [RUN_CNT_W-1:0]    runs_done_q;
    logic [BEAT_CNT_W-1:0]   beats_q;
    logic                    aborted_q;
    logic                    timeout_q;

    logic accept;
    logic inc_run;
    logic last_run;
    logic beat;
    logic wd_expired;

    assign beat     = mon_tvalid & mon_tready;
    assign last_run = (runs_done_q + RUN_CNT_W'(1)) == runs_q;

`ifdef ACCEL_RUN_CTRL_WATCHDOG_EN
    logic wd_en;
    logic wd_clr;

    assign wd_en  = (state_q == ST_START) || (state_q == ST_RUN) ||
                    (state_q == ST_DRAIN);
    assign wd_clr = (state_d != state_q) | ap_ready | ap_done | beat;

    accel_run_ctrl_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );
`else
    assign wd_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        inc_run = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    accept  = 1'b1;
                    state_d = (cmd_runs == '0) ? ST_DONE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (cmd_abort || wd_expired) begin
                    state_d = ST_DRAIN;
                end else if (ap_idle) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // ready+done together completes the invocation on the spot
                inc_run = ap_ready && ap_done;
                if (cmd_abort || wd_expired) begin
                    state_d = ST_DRAIN;
                end else if (ap_ready && ap_done) begin
                    state_d = last_run ? ST_DONE : ST_START;
                end else if (ap_ready) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                inc_run = ap_done;
                if (cmd_abort || wd_expired) begin
                    state_d = ST_DRAIN;
                end else if (ap_done) begin
                    state_d = last_run ? ST_DONE : ST_START;
                end
            end
            ST_DRAIN: begin
                inc_run = ap_done;
                if (ap_idle || wd_expired) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            use_enc_q   <= 1'b0;
            ap_start_q  <= 1'b0;
            runs_q      <= '0;
            runs_done_q <= '0;
            beats_q     <= '0;
            aborted_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ap_start_q <= (state_d == ST_START);
            if (accept) begin
                use_enc_q   <= cmd_use_enc;
                runs_q      <= cmd_runs;
                runs_done_q <= '0;
                beats_q     <= '0;
                aborted_q   <= 1'b0;
                timeout_q   <= 1'b0;
            end else begin
                if (inc_run) begin
                    runs_done_q <= runs_done_q + RUN_CNT_W'(1);
                end
                if (beat && sts_busy && (beats_q != '1)) begin
                    beats_q <= beats_q + BEAT_CNT_W'(1);
                end
                if ((state_d == ST_DRAIN) && (state_q != ST_DRAIN)) begin
                    aborted_q <= 1'b1;
                end
                if (wd_expired) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign USE_ENC       = use_enc_q;
    assign ap_start      = ap_start_q;
    assign sts_busy      = (state_q != ST_IDLE);
    assign sts_done      = (state_q == ST_DONE);
    assign sts_aborted   = aborted_q;
    assign sts_timeout   = timeout_q;
    assign sts_runs_done = runs_done_q;
    assign sts_beats     = beats_q;

endmodule

// File: tb/tb_accel_run_ctrl.sv
// Self-checking bench for accel_run_ctrl with a behavioural accelerator.
// Watchdog scenario is built only with ACCEL_RUN_CTRL_WATCHDOG_EN.
module tb_accel_run_ctrl;

    localparam int RW = 16;
    localparam int BW = 10;
    localparam int TO = 64;
    localparam int BMAX = (1 << BW) - 1;

    logic          ap_clk = 1'b0;
    logic          ap_rst = 1'b1;
    logic          cmd_start = 1'b0;
    logic          cmd_use_enc = 1'b0;
    logic [RW-1:0] cmd_runs = '0;
    logic          cmd_abort = 1'b0;
    logic          USE_ENC;
    logic          ap_start;
    logic          ap_ready = 1'b0;
    logic          ap_done = 1'b0;
    logic          ap_idle = 1'b1;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          sts_busy;
    logic          sts_done;
    logic          sts_aborted;
    logic          sts_timeout;
    logic [RW-1:0] sts_runs_done;
    logic [BW-1:0] sts_beats;

    int total = 0;
    int bad = 0;

    accel_run_ctrl #(
        .RUN_CNT_W(RW),
        .BEAT_CNT_W(BW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .cmd_start     (cmd_start),
        .cmd_use_enc   (cmd_use_enc),
        .cmd_runs      (cmd_runs),
        .cmd_abort     (cmd_abort),
        .USE_ENC       (USE_ENC),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .mon_tvalid    (mon_tvalid),
        .mon_tready    (mon_tready),
        .sts_busy      (sts_busy),
        .sts_done      (sts_done),
        .sts_aborted   (sts_aborted),
        .sts_timeout   (sts_timeout),
        .sts_runs_done (sts_runs_done),
        .sts_beats     (sts_beats)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge ap_clk);
    endtask

    task automatic accept(input bit enc, input int runs);
        cmd_start   = 1'b1;
        cmd_use_enc = enc;
        cmd_runs    = RW'(runs);
        step();
        cmd_start   = 1'b0;
        cmd_use_enc = 1'b0;
        cmd_runs    = '0;
    endtask

    // One accelerator invocation: ready in the rdy-th start cycle, done dn
    // cycles later (dn=0: same cycle). nb<0 gives random beats.
    task automatic invoke(input int rdy, input int dn, input int nb,
                          output int waited, output int hi,
                          output int leak, output int beats);
        waited = 0;
        hi     = 0;
        leak   = 0;
        beats  = 0;
        while (ap_start !== 1'b1 && waited < 100) begin
            waited++;
            step();
        end
        if (waited >= 100) return;
        for (int c = 1; c <= rdy; c++) begin
            if (ap_start === 1'b1) hi++;
            ap_ready = (c == rdy);
            ap_done  = (c == rdy) && (dn == 0);
            step();
        end
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        for (int d = 1; d <= dn; d++) begin
            if (ap_start !== 1'b0) leak++;
            if (nb < 0) begin
                mon_tvalid = 1'($urandom_range(0, 1));
                mon_tready = 1'($urandom_range(0, 1));
            end else begin
                mon_tvalid = (d <= nb);
                mon_tready = (d <= nb);
            end
            if (mon_tvalid && mon_tready) beats++;
            ap_done = (d == dn);
            step();
        end
        ap_done    = 1'b0;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1;
        step(3);
        total++;
        if ({USE_ENC, ap_start, sts_busy, sts_done, sts_aborted,
             sts_timeout} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {USE_ENC, ap_start, sts_busy, sts_done,
                      sts_aborted, sts_timeout});
        end
        total++;
        if (sts_runs_done !== '0 || sts_beats !== '0) begin
            bad++;
            $display("FAIL reset_counters runs=%0d beats=%0d exp=0",
                     sts_runs_done, sts_beats);
        end
        ap_rst = 1'b0;
        step();
    endtask

    task automatic test_single_enc();
        int w, hi, lk, nb;
        accept(1'b1, 1);
        total++;
        if (USE_ENC !== 1'b1 || sts_busy !== 1'b1) begin
            bad++;
            $display("FAIL single_accept use_enc=%b busy=%b exp=1 1",
                     USE_ENC, sts_busy);
        end
        invoke(3, 10, 8, w, hi, lk, nb);
        total++;
        if (w !== 1) begin
            bad++;
            $display("FAIL single_latency got=%0d exp=1", w);
        end
        total++;
        if (hi !== 3 || lk !== 0) begin
            bad++;
            $display("FAIL single_start_hi got=%0d/%0d exp=3/0", hi, lk);
        end
        total++;
        if (sts_done !== 1'b1 || sts_runs_done !== RW'(1) ||
            sts_beats !== BW'(8)) begin
            bad++;
            $display("FAIL single_end done=%b runs=%0d beats=%0d exp=1 1 8",
                     sts_done, sts_runs_done, sts_beats);
        end
        step();
        total++;
        if (sts_done !== 1'b0 || sts_busy !== 1'b0 || USE_ENC !== 1'b1) begin
            bad++;
            $display("FAIL single_after done=%b busy=%b enc=%b exp=0 0 1",
                     sts_done, sts_busy, USE_ENC);
        end
    endtask

    task automatic test_back_to_back();
        int w, hi, lk, nb, hs, gaps;
        hs   = 0;
        gaps = 0;
        accept(1'b0, 4);
        for (int i = 0; i < 4; i++) begin
            invoke(1, 0, 0, w, hi, lk, nb);
            if (hi == 1) hs++;
            if (i > 0 && w != 0) gaps++;
        end
        total++;
        if (hs !== 4 || gaps !== 0) begin
            bad++;
            $display("FAIL b2b_starts got=%0d gaps=%0d exp=4 0", hs, gaps);
        end
        total++;
        if (sts_done !== 1'b1 || sts_runs_done !== RW'(4)) begin
            bad++;
            $display("FAIL b2b_end done=%b runs=%0d exp=1 4",
                     sts_done, sts_runs_done);
        end
        step();
    endtask

    task automatic test_random_jobs();
        int w, hi, lk, nb, sum, gaps, runs, exp_b;
        bit enc;
        for (int j = 0; j < 6; j++) begin
            enc  = 1'($urandom_range(0, 1));
            runs = $urandom_range(1, 3);
            sum  = 0;
            gaps = 0;
            accept(enc, runs);
            for (int i = 0; i < runs; i++) begin
                invoke($urandom_range(1, 4), $urandom_range(0, 6), -1,
                       w, hi, lk, nb);
                sum += nb;
                if (i > 0 && w != 0) gaps++;
                if (lk != 0) gaps++;
            end
            exp_b = (sum > BMAX) ? BMAX : sum;
            total++;
            if (sts_done !== 1'b1 || sts_runs_done !== RW'(runs) ||
                sts_beats !== BW'(exp_b) || USE_ENC !== enc ||
                sts_aborted !== 1'b0 || gaps !== 0) begin
                bad++;
                $display("FAIL rand_job%0d done=%b runs=%0d/%0d beats=%0d/%0d enc=%b/%b ab=%b gaps=%0d",
                         j, sts_done, sts_runs_done, runs, sts_beats,
                         exp_b, USE_ENC, enc, sts_aborted, gaps);
            end
            step();
        end
    endtask

    task automatic test_select_guard();
        int w, hi, lk, nb, early, sel_bad;
        early   = 0;
        sel_bad = 0;
        accept(1'b1, 1);
        invoke(1, 0, 0, w, hi, lk, nb);
        step();
        ap_idle = 1'b0;
        accept(1'b0, 1);
        for (int i = 0; i < 20; i++) begin
            if (ap_start !== 1'b0) early++;
            if (USE_ENC !== 1'b0) sel_bad++;
            cmd_start   = 1'($urandom_range(0, 1));
            cmd_use_enc = 1'b1;
            cmd_runs    = RW'(0);
            step();
        end
        cmd_start   = 1'b0;
        cmd_use_enc = 1'b0;
        ap_idle     = 1'b1;
        total++;
        if (early !== 0 || sel_bad !== 0) begin
            bad++;
            $display("FAIL guard_hold early=%0d sel=%0d exp=0 0",
                     early, sel_bad);
        end
        step();
        total++;
        if (ap_start !== 1'b1 || USE_ENC !== 1'b0) begin
            bad++;
            $display("FAIL guard_release start=%b enc=%b exp=1 0",
                     ap_start, USE_ENC);
        end
        invoke(1, 2, 0, w, hi, lk, nb);
        total++;
        if (sts_done !== 1'b1 || sts_runs_done !== RW'(1) || w !== 0) begin
            bad++;
            $display("FAIL guard_end done=%b runs=%0d w=%0d exp=1 1 0",
                     sts_done, sts_runs_done, w);
        end
        step();
    endtask

    task automatic test_abort();
        int w, hi, lk, nb, waited, bad_drain;
        waited    = 0;
        bad_drain = 0;
        accept(1'b1, 3);
        invoke(2, 3, 0, w, hi, lk, nb);
        while (ap_start !== 1'b1 && waited < 100) begin
            waited++;
            step();
        end
        ap_ready = 1'b1;
        step();
        ap_ready = 1'b0;
        step(2);
        ap_done   = 1'b1;
        cmd_abort = 1'b1;
        ap_idle   = 1'b0;
        step();
        ap_done   = 1'b0;
        cmd_abort = 1'b0;
        total++;
        if (sts_runs_done !== RW'(2) || sts_aborted !== 1'b1 ||
            sts_done !== 1'b0 || ap_start !== 1'b0 || waited >= 100) begin
            bad++;
            $display("FAIL abort_drain runs=%0d ab=%b done=%b start=%b exp=2 1 0 0",
                     sts_runs_done, sts_aborted, sts_done, ap_start);
        end
        for (int i = 0; i < 3; i++) begin
            if (sts_done !== 1'b0 || sts_busy !== 1'b1) bad_drain++;
            step();
        end
        ap_idle = 1'b1;
        total++;
        if (bad_drain !== 0) begin
            bad++;
            $display("FAIL abort_wait_idle got=%0d exp=0", bad_drain);
        end
        step();
        total++;
        if (sts_done !== 1'b1 || sts_aborted !== 1'b1 ||
            sts_runs_done !== RW'(2)) begin
            bad++;
            $display("FAIL abort_done done=%b ab=%b runs=%0d exp=1 1 2",
                     sts_done, sts_aborted, sts_runs_done);
        end
        step();
        total++;
        if (sts_busy !== 1'b0 || sts_aborted !== 1'b1) begin
            bad++;
            $display("FAIL abort_sticky busy=%b ab=%b exp=0 1",
                     sts_busy, sts_aborted);
        end
    endtask

    task automatic test_zero_runs();
        int hi;
        hi = 0;
        accept(1'b1, 0);
        if (ap_start !== 1'b0) hi++;
        total++;
        if (sts_done !== 1'b1 || sts_aborted !== 1'b0 ||
            sts_runs_done !== '0) begin
            bad++;
            $display("FAIL zero_done done=%b ab=%b runs=%0d exp=1 0 0",
                     sts_done, sts_aborted, sts_runs_done);
        end
        step();
        if (ap_start !== 1'b0) hi++;
        step();
        if (ap_start !== 1'b0) hi++;
        total++;
        if (sts_busy !== 1'b0 || hi !== 0) begin
            bad++;
            $display("FAIL zero_idle busy=%b start_seen=%0d exp=0 0",
                     sts_busy, hi);
        end
    endtask

    task automatic test_saturate();
        int w, hi, lk, nb;
        accept(1'b0, 1);
        invoke(1, BMAX + 7, BMAX + 6, w, hi, lk, nb);
        total++;
        if (sts_beats !== BW'(BMAX) || nb !== BMAX + 6) begin
            bad++;
            $display("FAIL sat_beats got=%0d exp=%0d driven=%0d",
                     sts_beats, BMAX, nb);
        end
        step();
    endtask

`ifdef ACCEL_RUN_CTRL_WATCHDOG_EN
    task automatic test_watchdog();
        int waited, hi;
        waited = 0;
        hi     = 0;
        accept(1'b1, 1);
        while (ap_start !== 1'b1 && waited < 100) begin
            waited++;
            step();
        end
        while (ap_start === 1'b1 && hi < 200) begin
            hi++;
            step();
        end
        total++;
        if (hi !== TO || sts_timeout !== 1'b1 || sts_aborted !== 1'b1 ||
            sts_done !== 1'b0) begin
            bad++;
            $display("FAIL wdog_expire hi=%0d to=%b ab=%b done=%b exp=%0d 1 1 0",
                     hi, sts_timeout, sts_aborted, sts_done, TO);
        end
        step();
        total++;
        if (sts_done !== 1'b1 || sts_timeout !== 1'b1) begin
            bad++;
            $display("FAIL wdog_done done=%b to=%b exp=1 1",
                     sts_done, sts_timeout);
        end
        step();
    endtask
`endif

    task automatic test_reset_midrun();
        int waited;
        waited = 0;
        accept(1'b1, 2);
        while (ap_start !== 1'b1 && waited < 100) begin
            waited++;
            step();
        end
        ap_ready = 1'b1;
        step();
        ap_ready   = 1'b0;
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
        step(2);
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        total++;
        if (sts_beats !== BW'(2) || sts_busy !== 1'b1 || USE_ENC !== 1'b1) begin
            bad++;
            $display("FAIL midrun_pre beats=%0d busy=%b enc=%b exp=2 1 1",
                     sts_beats, sts_busy, USE_ENC);
        end
        ap_rst = 1'b1;
        step();
        total++;
        if ({USE_ENC, ap_start, sts_busy, sts_done, sts_aborted,
             sts_timeout} !== 6'b0 || sts_beats !== '0 ||
            sts_runs_done !== '0) begin
            bad++;
            $display("FAIL midrun_reset flags=%b beats=%0d runs=%0d exp=0",
                     {USE_ENC, ap_start, sts_busy, sts_done, sts_aborted,
                      sts_timeout}, sts_beats, sts_runs_done);
        end
        ap_rst = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_enc();
        test_back_to_back();
        test_random_jobs();
        test_select_guard();
        test_abort();
        test_zero_runs();
        test_saturate();
`ifdef ACCEL_RUN_CTRL_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accel_run_ctrl.md
# accel_run_ctrl

Run controller that sits upstream of the encoder/decoder select switch. It acts as the initiator of the ap_ctrl_hs handshake that the switch forwards to the selected accelerator, and it drives the switch's `USE_ENC` select. The select is changed only while the accelerators are idle. The block issues a programmed number of back-to-back invocations, counts output-stream beats, and reports completion, abort and (optionally) timeout status.

## Interface

Parameters:

- `RUN_CNT_W`, 16: width of the run-count command and its status.
- `BEAT_CNT_W`, 32: width of the output-beat counter.
- `TIMEOUT_CYCLES`, 1048576: watchdog limit in cycles. Used only when the watchdog is compiled in.

Ports:

- `ap_clk`  in  1  the single clock.
- `ap_rst`  in  1  reset; synchronous, active-high.
- `cmd_start`  in  1  single-cycle request to begin a job.
- `cmd_use_enc`  in  1  1 = encoder, 0 = decoder. Sampled with `cmd_start`.
- `cmd_runs`  in  RUN_CNT_W  number of invocations. Sampled with `cmd_start`.
- `cmd_abort`  in  1  terminates a job in progress.
- `USE_ENC`  out  1  select to the switch; registered.
- `ap_start`  out  1  start to the switch; registered.
- `ap_ready`  in  1  ready from the switch.
- `ap_done`  in  1  done from the switch.
- `ap_idle`  in  1  idle from the switch.
- `mon_tvalid`  in  1  output-stream TVALID (monitor tap).
- `mon_tready`  in  1  output-stream TREADY (monitor tap).
- `sts_busy`  out  1  high whenever the state is not IDLE.
- `sts_done`  out  1  one-cycle pulse at the end of every job.
- `sts_aborted`  out  1  sticky until the next accepted `cmd_start`.
- `sts_timeout`  out  1  sticky until the next accepted `cmd_start`. Tied to 0 without the watchdog.
- `sts_runs_done`  out  RUN_CNT_W  number of completed invocations.
- `sts_beats`  out  BEAT_CNT_W  number of output beats; saturating.

## Operation

States: IDLE, WAIT_IDLE, START, RUN, DRAIN, DONE.

- **IDLE**
  - `cmd_start` is accepted only in this state; it is ignored in every other state.
  - On accept: latch `cmd_use_enc` into `USE_ENC`, latch `cmd_runs`, clear `sts_runs_done`, `sts_beats`, `sts_aborted` and `sts_timeout`.
  - On accept with `cmd_runs` == 0: go to DONE; `ap_start` never asserts.
  - On accept otherwise: go to WAIT_IDLE.
- **WAIT_IDLE**
  - Minimum one cycle in this state, so the switch settles on the new select.
  - When `ap_idle` == 1, go to START.
- **START**
  - `ap_start` = 1.
  - On `ap_ready` == 1, go to RUN; `ap_start` drops in the same transition.
  - If `ap_ready` and `ap_done` are both 1 in the same cycle, count the invocation as complete immediately and apply the RUN completion rule.
- **RUN**
  - On `ap_done`: increment `sts_runs_done`.
  - If the new count equals the latched run count, go to DONE; otherwise go to START.
  - Back-to-back invocations do not revisit WAIT_IDLE, because the select is unchanged.
- **DRAIN**
  - Entered from WAIT_IDLE, START or RUN when `cmd_abort` == 1 (or on watchdog expiry).
  - `ap_start` = 0 and `sts_aborted` = 1.
  - Wait for `ap_idle` == 1, then go to DONE.
  - `ap_done` seen in DRAIN still increments `sts_runs_done`.
- **DONE**
  - `sts_done` = 1 for exactly one cycle, then go to IDLE.
- **Priority**
  - `cmd_abort` in the same cycle as `ap_done` in RUN: count the run, then go to DRAIN. Abort wins over returning to START.
  - `cmd_abort` in IDLE or DONE has no effect.
- **Select stability**
  - `USE_ENC` changes only on accept in IDLE. It is held constant through the whole job.
- **Beat counter**
  - Increments on `mon_tvalid` & `mon_tready` while `sts_busy` is high.
  - Saturates at all-ones.

## Timing

- **Reset values:** all outputs 0 (decoder selected), state IDLE.
- **Reset mid-job:** `ap_start` drops the cycle after reset is sampled. The block does not wait for `ap_idle`.
- **Status updates:**
  - `sts_busy` rises the cycle after `cmd_start` is accepted.
  - `USE_ENC` updates on that same edge.
- **Minimum latency from accept to `ap_start` high:** 2 cycles (one in WAIT_IDLE, when `ap_idle` is already 1).
- **Deassert:** `ap_start` deasserts on the edge after `ap_ready` is sampled high.
- **Back-to-back restart:** `ap_start` re-asserts on the edge after `ap_done` is sampled (RUN → START), 1 cycle.
- **Completion:** `sts_done` pulses 1 cycle after the final `ap_done`. `sts_busy` falls together with `sts_done`.
- **Counters:** all counters are registered, with 1-cycle visibility.

## Configuration

- **`ACCEL_RUN_CTRL_WATCHDOG_EN` defined**
  - A cycle counter runs in START, RUN and DRAIN.
  - It clears on every state change and on every `ap_ready`, `ap_done` or monitored beat.
  - On reaching `TIMEOUT_CYCLES` in START or RUN: set `sts_timeout` and behave exactly as `cmd_abort`.
  - On reaching `TIMEOUT_CYCLES` in DRAIN: set `sts_timeout` and go directly to DONE.
- **Not defined**
  - No counter logic is built. `sts_timeout` is constant 0.
  - A hung accelerator leaves the block in RUN or DRAIN until `cmd_abort` or reset.

## Structure

- **Package `accel_run_ctrl_pkg`:** the state enum typedef and the default width and timeout constants.
- **Sub-module `accel_run_ctrl_wdog`:** parameterised by `TIMEOUT_CYCLES`, with inputs `clr` and `en` and output `expired`. Instantiated only under `ACCEL_RUN_CTRL_WATCHDOG_EN`.

## Test plan

- **Single encoder run**
  - Stimulus: `cmd_runs`=1, `cmd_use_enc`=1, `ap_idle`=1, `ap_ready` 3 cycles after `ap_start`, `ap_done` 10 cycles later, 8 beats.
  - Required: `USE_ENC`=1, `ap_start` high exactly 3 cycles before `ap_ready` is sampled, `sts_runs_done`=1, `sts_beats`=8, one `sts_done` pulse.
- **Back-to-back runs**
  - Stimulus: `cmd_runs`=4, with `ap_ready` and `ap_done` asserted in the same cycle each run.
  - Required: 4 `ap_start` assertions, no WAIT_IDLE between runs, `sts_runs_done`=4.
- **Select guarded by idle**
  - Stimulus: accept with `cmd_use_enc`=0 while `ap_idle`=0 for 20 cycles.
  - Required: `ap_start` stays 0 until 1 cycle after `ap_idle` rises; `cmd_start` pulses during busy are ignored (`USE_ENC` unchanged).
- **Abort**
  - Stimulus: `cmd_abort` in RUN in the same cycle as `ap_done`, with `cmd_runs`=3.
  - Required: `sts_runs_done`=2, state goes to DRAIN, then `sts_done` and `sts_aborted`=1 after `ap_idle`.
- **Edge cases**
  - Stimulus: `cmd_runs`=0.
  - Required: `sts_done` pulses 1 cycle after accept; `ap_start` never asserts.
  - Stimulus: 2^32 + 5 beats.
  - Required: `sts_beats` saturates at 0xFFFFFFFF.
- **Watchdog and reset**
  - Stimulus: with the macro defined and `TIMEOUT_CYCLES`=64, `ap_ready` is never asserted.
  - Required: `sts_timeout`=1 after 64 cycles in START, then DRAIN, then DONE.
  - Stimulus: reset mid-RUN.
  - Required: all outputs 0 on the next cycle.
